adder_tap_pipe: RTL

ADDER_TAP_PIPE -- requirements
Module: adder_tap_pipe

---
 rtl/adder_tap_pipe.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/adder_tap_pipe.sv
// adder_tap_pipe
//   Two-stage valid/ready arithmetic pipeline with an internal accumulator.
//   Stage 1 computes add / subtract / accumulate / read-and-clear on accept.
//   Stage 2 re-registers the result and derives the tap bits (p, q) and the
//   zero flag, so every output belongs to the same beat.
//
// Parameters
//   WIDTH   operand/result width (2..32)
//   TAP_LO  result bit driven onto p
//   TAP_HI  result bit driven onto q
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat offered
//   in_ready   out  beat accepted when in_valid && in_ready
//   a, b       in   operands
//   op         in   00 A+B, 01 A-B, 10 ACC+A, 11 read-and-clear ACC
//   out_valid  out  result beat present
//   out_ready  in   downstream takes the beat when out_valid && out_ready
//   s          out  result
//   cout       out  carry (add/acc) or no-borrow (sub)
//   ovf        out  two's-complement signed overflow
//   p, q       out  s[TAP_LO], s[TAP_HI]
//   zero       out  s == 0
module adder_tap_pipe #(
    parameter int WIDTH  = 4,
    parameter int TAP_LO = 0,
    parameter int TAP_HI = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             p,
    output logic             q,
    output logic             zero
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    // Signed overflow of x + y giving r: same-sign operands, result sign differs.
    function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow of x - y giving r: opposite-sign operands, result sign differs from x.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Stage registers and accumulator
    logic             r_v1;
    logic [WIDTH-1:0] r_s1;
    logic             r_c1;
    logic             r_o1;
    logic             r_v2;
    logic [WIDTH-1:0] r_s2;
    logic             r_c2;
    logic             r_o2;
    logic             r_p2;
    logic             r_q2;
    logic             r_z2;
    logic [WIDTH-1:0] r_acc;

    // Combinational datapath / handshake
    logic [WIDTH:0]   w_add_ext;
    logic [WIDTH:0]   w_sub_ext;
    logic [WIDTH:0]   w_acc_ext;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_adv;
    logic             w_accept;

    // Stage 2 can take a new beat when empty or when its beat is leaving.
    assign w_adv     = !r_v2 || out_ready;
    assign in_ready  = !r_v1 || !r_v2 || out_ready;
    assign w_accept  = in_valid && in_ready;

    assign w_add_ext = {1'b0, a} + {1'b0, b};
    assign w_sub_ext = {1'b0, a} - {1'b0, b};
    assign w_acc_ext = {1'b0, r_acc} + {1'b0, a};

    // Stage 1 result, flags and next accumulator value for the offered op
    always_comb begin
        w_res     = {WIDTH{1'b0}};
        w_cout    = 1'b0;
        w_ovf     = 1'b0;
        w_acc_nxt = r_acc;
        case (op)
            OP_ADD: begin
                w_res  = w_add_ext[WIDTH-1:0];
                w_cout = w_add_ext[WIDTH];
                w_ovf  = add_ovf(a, b, w_add_ext[WIDTH-1:0]);
            end
            OP_SUB: begin
                w_res  = w_sub_ext[WIDTH-1:0];
                // The extended difference goes negative exactly when a < b.
                w_cout = ~w_sub_ext[WIDTH];
                w_ovf  = sub_ovf(a, b, w_sub_ext[WIDTH-1:0]);
            end
            OP_ACC: begin
                w_res     = w_acc_ext[WIDTH-1:0];
                w_cout    = w_acc_ext[WIDTH];
                w_ovf     = add_ovf(r_acc, a, w_acc_ext[WIDTH-1:0]);
                w_acc_nxt = w_acc_ext[WIDTH-1:0];
            end
            OP_CLR: begin
                w_res     = r_acc;
                w_acc_nxt = {WIDTH{1'b0}};
            end
            default: begin
                w_res     = {WIDTH{1'b0}};
                w_acc_nxt = r_acc;
            end
        endcase
    end

    // Stage 1 capture and accumulator update on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_s1  <= {WIDTH{1'b0}};
            r_c1  <= 1'b0;
            r_o1  <= 1'b0;
            r_acc <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_v1  <= 1'b1;
            r_s1  <= w_res;
            r_c1  <= w_cout;
            r_o1  <= w_ovf;
            r_acc <= w_acc_nxt;
        end else if (w_adv) begin
            r_v1  <= 1'b0;
        end
    end

    // Stage 2 load; data only changes when a real beat moves in, so a
    // stalled beat stays stable and a drained stage keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_s2 <= {WIDTH{1'b0}};
            r_c2 <= 1'b0;
            r_o2 <= 1'b0;
            r_p2 <= 1'b0;
            r_q2 <= 1'b0;
            r_z2 <= 1'b0;
        end else if (w_adv) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2 <= r_s1;
                r_c2 <= r_c1;
                r_o2 <= r_o1;
                r_p2 <= r_s1[TAP_LO];
                r_q2 <= r_s1[TAP_HI];
                r_z2 <= (r_s1 == {WIDTH{1'b0}});
            end
        end
    end

    assign out_valid = r_v2;
    assign s         = r_s2;
    assign cout      = r_c2;
    assign ovf       = r_o2;
    assign p         = r_p2;
    assign q         = r_q2;
    assign zero      = r_z2;

endmodule
